// File: rtl/multi_port_register_file.sv
// multi_port_register_file: multi-ported register file with write bypass, busy scoreboard and sequential zero-fill
// Ports: clk/resetN clock and asynchronous active-low reset;
//   readIndex/readData/readBusy per read port: source index, combinational data, pending-write flag;
//   writeEnable/writeIndex/writeData per write port: strobe, destination index, data;
//   reserveEnable/reserveIndex set the busy bit of a register at issue time;
//   clearRequest starts a one-register-per-cycle zero-fill, clearBusy is high while it runs.
module multi_port_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int READ_PORTS = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG = 1,
  localparam int IDX_W = $clog2(REG_COUNT)
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic [READ_PORTS*IDX_W-1:0]      readIndex,
  output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
  output logic [READ_PORTS-1:0]            readBusy,
  input  logic [WRITE_PORTS-1:0]           writeEnable,
  input  logic [WRITE_PORTS*IDX_W-1:0]     writeIndex,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeData,
  input  logic                             reserveEnable,
  input  logic [IDX_W-1:0]                 reserveIndex,
  input  logic                             clearRequest,
  output logic                             clearBusy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [IDX_W-1:0] counter;
  logic [IDX_W-1:0] wIdx [WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wDat [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] writeLive;
  logic reserveLive;
  // A write is live only in IDLE and when not aimed at the hardwired zero register;
  // the same qualifier gates both commit and bypass so they can never disagree.
  for (genvar w = 0; w < WRITE_PORTS; w++) begin : gWr
    assign wIdx[w] = writeIndex[w*IDX_W +: IDX_W];
    assign wDat[w] = writeData[w*DATA_WIDTH +: DATA_WIDTH];
    assign writeLive[w] = state == IDLE && writeEnable[w] && !(ZERO_REG != 0 && wIdx[w] == '0);
  end
  assign reserveLive = reserveEnable && !(ZERO_REG != 0 && reserveIndex == '0);
  assign clearBusy = state == CLEAR;
  // Later ports are assigned last so the highest-numbered port wins; the reserve
  // follows the write-clears so a same-cycle reserve leaves the register busy.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      busy <= '0;
      counter <= '0;
      state <= IDLE;
    end else if (state == CLEAR) begin
      regs[counter] <= '0;
      busy[counter] <= 1'b0;
      counter <= counter + 1'b1;
      if (counter == IDX_W'(REG_COUNT - 1)) state <= IDLE;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++)
        if (writeLive[w]) begin
          regs[wIdx[w]] <= wDat[w];
          busy[wIdx[w]] <= 1'b0;
        end
      if (reserveLive) busy[reserveIndex] <= 1'b1;
      if (clearRequest) begin
        state <= CLEAR;
        counter <= '0;
      end
    end
  for (genvar p = 0; p < READ_PORTS; p++) begin : gRd
    logic [IDX_W-1:0] rIdx;
    logic [DATA_WIDTH-1:0] rDat;
    logic rBusy;
    assign rIdx = readIndex[p*IDX_W +: IDX_W];
    always_comb begin
      rDat = regs[rIdx];
      rBusy = busy[rIdx];
      for (int w = 0; w < WRITE_PORTS; w++)
        if (writeLive[w] && wIdx[w] == rIdx) begin
          rDat = wDat[w];
          rBusy = 1'b0;
        end
      if (ZERO_REG != 0 && rIdx == '0) begin
        rDat = '0;
        rBusy = 1'b0;
      end
    end
    assign readData[p*DATA_WIDTH +: DATA_WIDTH] = rDat;
    assign readBusy[p] = rBusy;
  end
endmodule
